mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the single-cycle core's instruction-fetch
//  port (pc/instr) and data port (addr/writedata/memwrite/readdata).
//  Grants one access per cycle and returns read data after fixed MEM_LAT cycles, tagged to the
//  owner. Generates per-port grants so the core's stall logic can hold pc/addr until served.
// PARAMETERS
//  AW       32  address width (byte address, word-aligned; bits [1:0] ignored)
//  DW       32  data width
//  MEM_LAT  1   memory read latency in cycles, legal 1..4
//  MAX_DRUN 4   max consecutive data grants while fetch waits, legal 1..15
// PORTS
//  clk        in   1   clock, all state on posedge
//  reset      in   1   asynchronous, active-high
//  if_req     in   1   fetch request; held with if_addr until if_gnt
//  if_addr    in   AW  fetch address (pc)
//  if_gnt     out  1   fetch accepted this cycle
//  if_rvalid  out  1   if_rdata valid (instr)
//  if_rdata   out  DW  fetched word
//  d_req      in   1   data request; held with d_we/d_addr/d_wdata until d_gnt
//  d_we       in   1   1 = store (memwrite), 0 = load
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data (writedata)
//  d_gnt      out  1   data accepted this cycle
//  d_rvalid   out  1   load data valid, or store acknowledge
//  d_rdata    out  DW  load data (readdata); 0 on store ack
//  mem_en     out  1   memory access this cycle
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  Reset: all outputs 0, drun counter 0, tag pipe empty. Reset mid-operation drops in-flight
//   responses; no rvalid is issued for them after reset release.
//  Grant (combinational, same cycle as req): at most one of if_gnt/d_gnt per cycle.
//   - Only one requester: it wins.
//   - Both: data wins unless drun == MAX_DRUN, then fetch wins.
//  drun: +1 on each d_gnt while if_req=1 (saturates at MAX_DRUN). Clears on if_gnt or if_req=0.
//  mem_en = if_gnt|d_gnt. mem_we = d_gnt & d_we. mem_addr/mem_wdata are muxed from the winner.
//   mem_wdata = 0 when not writing.
//  Tag pipe: MEM_LAT-deep shift register of src_t {NONE, IF, D} plus is_write bit.
//   Entry pushed every cycle, NONE when idle.
//  Response at pipe exit:
//   - IF: if_rvalid=1, if_rdata=mem_rdata.
//   - D load: d_rvalid=1, d_rdata=mem_rdata.
//   - D store: d_rvalid=1, d_rdata=0.
//   - NONE: rvalid=0, rdata holds its last value.
//  Latency: grant at cycle t -> rvalid at t+MEM_LAT, exactly one pulse per grant, in grant order.
//   Back-to-back grants give back-to-back responses; throughput is 1 access per cycle.
//  Port rules:
//   - A requester dropping req before gnt is legal (request withdrawn).
//   - Changing addr while req=1 and not granted is a protocol error, unchecked in RTL;
//     the bench asserts it.
//  Simultaneous response exit and new grant in the same cycle: both occur, no conflict.
// STRUCTURE
//  mem_arb_pkg:
//   - typedef enum logic [1:0] src_t {SRC_NONE, SRC_IF, SRC_D}
//   - struct tag_t {src_t src; logic wr;}
//   - localparam MAX_LAT = 4
//  Sub-module mem_resp_tag_pipe (MEM_LAT-deep tag_t shift register, async reset to SRC_NONE).
//  Top holds the grant logic, drun counter, memory mux and response demux.
// TESTING
//  1. Fetch only, if_addr 0,4,8 consecutively, MEM_LAT=1 -> if_gnt 3 cycles,
//     if_rvalid cycles 2-4 with mem words 0,1,2.
//  2. Both request continuously, MAX_DRUN=4 -> grant pattern D,D,D,D,IF repeating;
//     drun never exceeds 4.
//  3. Store d_addr=0x10 d_wdata=0xDEADBEEF, then load 0x10 -> store ack d_rdata=0,
//     then load d_rdata=0xDEADBEEF.
//  4. MEM_LAT=3, alternating IF/D grants for 6 cycles -> each rvalid 3 cycles after its grant,
//     order preserved, no cross-port data.
//  5. Assert reset while 2 reads are in flight -> outputs 0 immediately; no rvalid after release.
//  6. d_req withdrawn before grant while if_req=1 -> if_gnt same cycle; no d_rvalid ever.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_D    = 2'd2
    } src_t;

    typedef struct packed {
        src_t src;
        logic wr;
    } tag_t;

    localparam int unsigned MAX_LAT = 4;
    localparam int unsigned DRUN_W  = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/data ports and memory-side port of the shared memory arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Core and memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_resp_tag_pipe.sv
// Delays the owner tag of each memory access by the memory read latency.
module mem_resp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t [DEPTH-1:0] pipe_q;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or posedge reset) begin
                if (reset) pipe_q <= '0;
                else       pipe_q <= tag_in;
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge reset) begin
                if (reset) pipe_q <= '0;
                else       pipe_q <= {pipe_q[DEPTH-2:0], tag_in};
            end
        end
    endgenerate

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports;
// one grant per cycle, responses returned to their owner MEM_LAT cycles later.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned MAX_DRUN = 4
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [DRUN_W-1:0] DRUN_LIMIT = DRUN_W'(MAX_DRUN);

    logic [DRUN_W-1:0] drun_q;
    logic              if_gnt_c;
    logic              d_gnt_c;
    logic [AW-1:0]     addr_c;
    logic [DW-1:0]     wdata_c;
    tag_t              tag_in_c;
    tag_t              tag_exit;
    logic              if_hit_c;
    logic              d_hit_c;
    logic [DW-1:0]     d_resp_c;
    logic [DW-1:0]     if_rdata_q;
    logic [DW-1:0]     d_rdata_q;

    // Data has priority until it has starved a waiting fetch MAX_DRUN times in a row
    always_comb begin
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        if (!reset) begin
            if (bus.if_req && bus.d_req) begin
                if (drun_q == DRUN_LIMIT) if_gnt_c = 1'b1;
                else                      d_gnt_c  = 1'b1;
            end else begin
                if_gnt_c = bus.if_req;
                d_gnt_c  = bus.d_req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drun_q <= '0;
        end else if (if_gnt_c || !bus.if_req) begin
            drun_q <= '0;
        end else if (d_gnt_c && drun_q != DRUN_LIMIT) begin
            drun_q <= drun_q + DRUN_W'(1);
        end
    end

    // Memory request mux and owner tag for the pipe
    always_comb begin
        addr_c   = '0;
        wdata_c  = '0;
        tag_in_c = '{src: SRC_NONE, wr: 1'b0};
        if (if_gnt_c) begin
            addr_c       = bus.if_addr;
            tag_in_c.src = SRC_IF;
        end else if (d_gnt_c) begin
            addr_c       = bus.d_addr;
            tag_in_c.src = SRC_D;
            tag_in_c.wr  = bus.d_we;
            if (bus.d_we) wdata_c = bus.d_wdata;
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_en    = if_gnt_c | d_gnt_c;
    assign bus.mem_we    = d_gnt_c & bus.d_we;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;

    mem_resp_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in_c),
        .tag_out (tag_exit)
    );

    // Response demux; read data lines hold between responses
    always_comb begin
        if_hit_c = (tag_exit.src == SRC_IF);
        d_hit_c  = (tag_exit.src == SRC_D);
        d_resp_c = tag_exit.wr ? '0 : bus.mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_hit_c) if_rdata_q <= bus.mem_rdata;
            if (d_hit_c)  d_rdata_q  <= d_resp_c;
        end
    end

    assign bus.if_rvalid = if_hit_c;
    assign bus.if_rdata  = if_hit_c ? bus.mem_rdata : if_rdata_q;
    assign bus.d_rvalid  = d_hit_c;
    assign bus.d_rdata   = d_hit_c ? d_resp_c : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) share stimulus and
// are compared each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int MAX_DRUN = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

    assign b1.if_req = if_req;  assign b3.if_req = if_req;
    assign b1.if_addr = if_addr; assign b3.if_addr = if_addr;
    assign b1.d_req = d_req;    assign b3.d_req = d_req;
    assign b1.d_we = d_we;      assign b3.d_we = d_we;
    assign b1.d_addr = d_addr;  assign b3.d_addr = d_addr;
    assign b1.d_wdata = d_wdata; assign b3.d_wdata = d_wdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_DRUN(MAX_DRUN)) u_dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .MAX_DRUN(MAX_DRUN)) u_dut3 (
        .clk(clk), .reset(reset), .bus(b3.slave));

    // Synchronous memories; words initialised to their index; idle read slots carry noise
    logic [31:0] pm1 [256];
    logic [31:0] pm3 [256];
    logic [31:0] rp1;
    logic [31:0] rp3 [3];

    always @(posedge clk) begin
        if (reset) for (int i = 0; i < 256; i++) pm1[i] <= 32'(i);
        else if (b1.mem_en && b1.mem_we) pm1[b1.mem_addr[9:2]] <= b1.mem_wdata;
        rp1 <= (b1.mem_en && !b1.mem_we) ? pm1[b1.mem_addr[9:2]] : $urandom;
    end

    always @(posedge clk) begin
        if (reset) for (int i = 0; i < 256; i++) pm3[i] <= 32'(i);
        else if (b3.mem_en && b3.mem_we) pm3[b3.mem_addr[9:2]] <= b3.mem_wdata;
        rp3[0] <= (b3.mem_en && !b3.mem_we) ? pm3[b3.mem_addr[9:2]] : $urandom;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    assign b1.mem_rdata = rp1;
    assign b3.mem_rdata = rp3[2];

    // Reference model: expected responses queued with their due cycle
    typedef struct {
        int          due;
        logic        is_if;
        logic        wr;
        logic [31:0] data;
    } resp_t;

    resp_t       q1[$];
    resp_t       q3[$];
    logic [31:0] ref_mem [256];
    int          drun_m;
    int          cyc;
    logic [31:0] last_if1, last_d1, last_if3, last_d3;
    logic        p_if_hold, p_d_hold;
    logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
    logic        p_d_we;
    int          checks = 0;
    int          errors = 0;

    logic        s_ig, s_dg, s_ifv1, s_dv1, s_ifv3, s_dv3;
    logic [31:0] s_ifd1, s_dd1, s_ifd3, s_dd3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q3.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
        drun_m = 0;
        last_if1 = '0; last_d1 = '0; last_if3 = '0; last_d3 = '0;
        p_if_hold = 1'b0; p_d_hold = 1'b0;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic pop_exp(input int k, output bit v, output resp_t r);
        v = 1'b0;
        r = '{due: 0, is_if: 1'b0, wr: 1'b0, data: 32'd0};
        if (k == 0) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin v = 1'b1; r = q1.pop_front(); end
        end else begin
            if (q3.size() > 0 && q3[0].due == cyc) begin v = 1'b1; r = q3.pop_front(); end
        end
    endtask

    task automatic check_resp(input int k, input logic ifv, input logic [31:0] ifd,
                              input logic dv, input logic [31:0] dd);
        bit          v;
        resp_t       r;
        logic [31:0] e_ifd, e_dd;
        string       p;
        p = (k == 0) ? "L1" : "L3";
        pop_exp(k, v, r);
        e_ifd = (k == 0) ? last_if1 : last_if3;
        e_dd  = (k == 0) ? last_d1 : last_d3;
        if (v && r.is_if)  e_ifd = r.data;
        if (v && !r.is_if) e_dd = r.wr ? 32'd0 : r.data;
        chk({p, " if_rvalid"}, 64'(ifv), 64'(v && r.is_if));
        chk({p, " if_rdata"}, 64'(ifd), 64'(e_ifd));
        chk({p, " d_rvalid"}, 64'(dv), 64'(v && !r.is_if));
        chk({p, " d_rdata"}, 64'(dd), 64'(e_dd));
        if (k == 0) begin last_if1 = e_ifd; last_d1 = e_dd; end
        else        begin last_if3 = e_ifd; last_d3 = e_dd; end
    endtask

    task automatic check_req(input string p, input logic ig, input logic dg, input logic en,
                             input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [5:0] e_ctl, input logic [31:0] e_a, input logic [31:0] e_wd);
        chk({p, " gnt/en/we"}, 64'({ig, dg, en, we}), 64'(e_ctl[3:0]));
        chk({p, " mem_addr"}, 64'(a), 64'(e_a));
        chk({p, " mem_wdata"}, 64'(wd), 64'(e_wd));
    endtask

    // One clock: inputs already applied; check at negedge, then advance the model
    task automatic cycle();
        logic        e_ig, e_dg, e_we;
        logic [31:0] e_a, e_wd;
        resp_t       r;
        @(negedge clk);
        if (p_if_hold && if_req) chk("protocol if_addr held", 64'(if_addr), 64'(p_if_addr));
        if (p_d_hold && d_req) begin
            chk("protocol d_addr held", 64'(d_addr), 64'(p_d_addr));
            chk("protocol d_we/wdata held", 64'({d_we, d_wdata}), 64'({p_d_we, p_d_wdata}));
        end
        e_ig = 1'b0; e_dg = 1'b0;
        if (if_req && d_req) begin
            if (drun_m == MAX_DRUN) e_ig = 1'b1;
            else                    e_dg = 1'b1;
        end else begin
            e_ig = if_req; e_dg = d_req;
        end
        e_we = e_dg && d_we;
        e_a  = e_ig ? if_addr : (e_dg ? d_addr : 32'd0);
        e_wd = e_we ? d_wdata : 32'd0;
        check_req("L1", b1.if_gnt, b1.d_gnt, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata,
                  {2'b00, e_ig, e_dg, e_ig | e_dg, e_we}, e_a, e_wd);
        check_req("L3", b3.if_gnt, b3.d_gnt, b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata,
                  {2'b00, e_ig, e_dg, e_ig | e_dg, e_we}, e_a, e_wd);
        s_ig = b1.if_gnt; s_dg = b1.d_gnt;
        s_ifv1 = b1.if_rvalid; s_ifd1 = b1.if_rdata; s_dv1 = b1.d_rvalid; s_dd1 = b1.d_rdata;
        s_ifv3 = b3.if_rvalid; s_ifd3 = b3.if_rdata; s_dv3 = b3.d_rvalid; s_dd3 = b3.d_rdata;
        check_resp(0, s_ifv1, s_ifd1, s_dv1, s_dd1);
        check_resp(1, s_ifv3, s_ifd3, s_dv3, s_dd3);
        if (e_ig || e_dg) begin
            r.is_if = e_ig;
            r.wr    = e_we;
            r.data  = e_ig ? ref_mem[if_addr[9:2]] : (e_we ? 32'd0 : ref_mem[d_addr[9:2]]);
            r.due   = cyc + 1; q1.push_back(r);
            r.due   = cyc + 3; q3.push_back(r);
            if (e_we) ref_mem[d_addr[9:2]] = d_wdata;
        end
        if (e_ig || !if_req)                  drun_m = 0;
        else if (e_dg && drun_m < MAX_DRUN)   drun_m++;
        p_if_hold = if_req && !e_ig; p_if_addr = if_addr;
        p_d_hold = d_req && !e_dg; p_d_addr = d_addr; p_d_we = d_we; p_d_wdata = d_wdata;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string p);
        chk({p, " L1 ctl"}, 64'({b1.if_gnt, b1.d_gnt, b1.if_rvalid, b1.d_rvalid, b1.mem_en, b1.mem_we}), 64'd0);
        chk({p, " L1 rdata"}, {b1.if_rdata, b1.d_rdata}, 64'd0);
        chk({p, " L1 mem"}, {b1.mem_addr, b1.mem_wdata}, 64'd0);
        chk({p, " L3 ctl"}, 64'({b3.if_gnt, b3.d_gnt, b3.if_rvalid, b3.d_rvalid, b3.mem_en, b3.mem_we}), 64'd0);
        chk({p, " L3 rdata"}, {b3.if_rdata, b3.d_rdata}, 64'd0);
        chk({p, " L3 mem"}, {b3.mem_addr, b3.mem_wdata}, 64'd0);
    endtask

    initial begin
        int          ifc, dc;
        logic        e_if;
        logic [31:0] fa, da;
        cyc = 0;
        reset = 1'b1;
        model_reset();
        // Requests pending during reset must not be granted
        drive(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h5);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;

        // Fetch-only stream 0,4,8
        drive(1'b1, 32'h0, 1'b0, 1'b0, 0, 0); cycle();
        chk("t1 if_gnt c1", 64'(s_ig), 64'd1);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 0, 0); cycle();
        chk("t1 if_gnt c2", 64'(s_ig), 64'd1);
        chk("t1 rsp c2", 64'({s_ifv1, s_ifd1}), 64'({1'b1, 32'd0}));
        drive(1'b1, 32'h8, 1'b0, 1'b0, 0, 0); cycle();
        chk("t1 rsp c3", 64'({s_ifv1, s_ifd1}), 64'({1'b1, 32'd1}));
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0); cycle();
        chk("t1 rsp c4", 64'({s_ifv1, s_ifd1}), 64'({1'b1, 32'd2}));
        cycle();
        chk("t1 rdata hold", 64'({s_ifv1, s_ifd1}), 64'({1'b0, 32'd2}));
        repeat (2) cycle();

        // Both requesting: D,D,D,D,IF repeating
        fa = 32'h100; da = 32'h200;
        for (int k = 0; k < 15; k++) begin
            drive(1'b1, fa, 1'b1, 1'b0, da, 0);
            cycle();
            e_if = ((k % 5) == 4);
            chk($sformatf("t2 grant k%0d", k), 64'({s_ig, s_dg}), 64'({e_if, !e_if}));
            if (s_ig) fa += 4;
            if (s_dg) da += 4;
        end
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        repeat (4) cycle();

        // Store then load of the same word
        drive(1'b0, 0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF); cycle();
        drive(1'b0, 0, 1'b1, 1'b0, 32'h10, 0); cycle();
        chk("t3 L1 store ack", 64'({s_dv1, s_dd1}), 64'({1'b1, 32'd0}));
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0); cycle();
        chk("t3 L1 load", 64'({s_dv1, s_dd1}), 64'({1'b1, 32'hDEADBEEF}));
        cycle();
        chk("t3 L3 store ack", 64'({s_dv3, s_dd3}), 64'({1'b1, 32'd0}));
        cycle();
        chk("t3 L3 load", 64'({s_dv3, s_dd3}), 64'({1'b1, 32'hDEADBEEF}));
        repeat (2) cycle();

        // Alternating fetch/load grants, checked on the latency-3 instance
        ifc = 0; dc = 0;
        for (int j = 0; j < 10; j++) begin
            if (j < 6 && (j % 2) == 0)  drive(1'b1, 32'(32'h40 + 4 * j), 1'b0, 1'b0, 0, 0);
            else if (j < 6)             drive(1'b0, 0, 1'b1, 1'b0, 32'(32'h200 + 4 * j), 0);
            else                        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
            cycle();
            chk($sformatf("t4 L3 valid j%0d", j), 64'({s_ifv3, s_dv3}),
                64'({(j >= 3 && j <= 8 && ((j - 3) % 2) == 0), (j >= 3 && j <= 8 && ((j - 3) % 2) == 1)}));
            if (s_ifv3) chk($sformatf("t4 L3 if_rdata j%0d", j), 64'(s_ifd3), 64'(16 + j - 3));
            if (s_dv3)  chk($sformatf("t4 L3 d_rdata j%0d", j), 64'(s_dd3), 64'(128 + j - 3));
            ifc += int'(s_ifv3); dc += int'(s_dv3);
        end
        chk("t4 if pulses", 64'(ifc), 64'd3);
        chk("t4 d pulses", 64'(dc), 64'd3);

        // Reset while reads are in flight
        drive(1'b1, 32'h20, 1'b0, 1'b0, 0, 0); cycle();
        drive(1'b1, 32'h24, 1'b0, 1'b0, 0, 0); cycle();
        drive(1'b1, 32'h28, 1'b1, 1'b0, 32'h30, 0);
        #2;
        reset = 1'b1;
        #1;
        check_zero("t5 reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        ifc = 0;
        for (int j = 0; j < 6; j++) begin
            cycle();
            ifc += int'(s_ifv1) + int'(s_ifv3) + int'(s_dv1) + int'(s_dv3);
        end
        chk("t5 no rvalid after reset", 64'(ifc), 64'd0);

        // Data request withdrawn after losing to fetch
        dc = 0; ifc = 0;
        fa = 32'h80; da = 32'h180;
        for (int k = 0; k < 10; k++) begin
            if (k < 4)       drive(1'b1, fa, 1'b1, 1'b0, 32'(da + 4 * k), 0);
            else if (k == 4) drive(1'b1, fa, 1'b1, 1'b0, 32'h300, 0);
            else if (k == 5) drive(1'b1, 32'(fa + 4), 1'b0, 1'b0, 0, 0);
            else             drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
            cycle();
            if (k == 4) chk("t6 fetch wins", 64'({s_ig, s_dg}), 64'({1'b1, 1'b0}));
            if (k == 5) chk("t6 withdraw gnt", 64'({s_ig, s_dg}), 64'({1'b1, 1'b0}));
            dc += int'(s_dv1); ifc += int'(s_dv3);
        end
        chk("t6 L1 d pulses", 64'(dc), 64'd4);
        chk("t6 L3 d pulses", 64'(ifc), 64'd4);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (p_if_hold) if_req = ($urandom_range(0, 9) != 0);
            else begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = $urandom & 32'h3ff;
            end
            if (p_d_hold) d_req = ($urandom_range(0, 9) != 0);
            else begin
                d_req   = ($urandom_range(0, 99) < 60);
                d_we    = ($urandom_range(0, 2) == 0);
                d_addr  = $urandom & 32'h3ff;
                d_wdata = $urandom;
            end
            cycle();
        end
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
